// File: rtl/hex_display_ctrl.sv
// Avalon-MM owner of the six 7-segment digits and four push-buttons: VALUE/CTRL registers,
// debounced key commands, blink/scroll sequencing. Optional macro HEX_BCD_EN selects BCD key arithmetic.
module hex_display_ctrl #(
    parameter int unsigned TICK_DIV        = 25000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [3:0]  key_export,
    output logic [6:0]  hex_0_export,
    output logic [6:0]  hex_1_export,
    output logic [6:0]  hex_2_export,
    output logic [6:0]  hex_3_export,
    output logic [6:0]  hex_4_export,
    output logic [6:0]  hex_5_export
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [31:0] CTRL_MASK = 32'h0000_3F07;

    typedef enum logic [1:0] {
        ADDR_VALUE  = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_KEYCNT = 2'd3
    } reg_addr_e;

    reg_addr_e   addr;
    logic [23:0] value_q, value_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [15:0] keycnt_q, keycnt_d;
    logic [2:0]  offset_q, offset_d;
    logic        phase_q, phase_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic        tick;
    logic [3:0]  ksync1_q, ksync2_q;
    logic [3:0]  kdb_q, kdb_d;
    logic [DW-1:0] kcnt_q [4];
    logic [DW-1:0] kcnt_d [4];
    logic [3:0]  press;
    logic [2:0]  npress;
    logic [31:0] rdata_q, rdata_d;
    logic [6:0]  seg_q [6];
    logic [6:0]  seg_d [6];
    logic        wr_value, wr_ctrl, wr_keycnt;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef HEX_BCD_EN
    function automatic logic is_bcd(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int unsigned k = 0; k < 6; k++) begin
            if (r[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
        end
        return r;
    endfunction
`endif

    function automatic logic [23:0] val_inc(input logic [23:0] v);
`ifdef HEX_BCD_EN
        logic [23:0] r;
        logic        c;
        if (is_bcd(v)) begin
            r = v;
            c = 1'b1;
            for (int unsigned k = 0; k < 6; k++) begin
                if (c) begin
                    if (r[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
                    else begin
                        r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end else begin
            r = clamp_bcd(v + 24'd1);
        end
        return r;
`else
        return v + 24'd1;
`endif
    endfunction

    function automatic logic [23:0] val_dec(input logic [23:0] v);
`ifdef HEX_BCD_EN
        logic [23:0] r;
        logic        b;
        if (is_bcd(v)) begin
            r = v;
            b = 1'b1;
            for (int unsigned k = 0; k < 6; k++) begin
                if (b) begin
                    if (r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
                    else begin
                        r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                        b = 1'b0;
                    end
                end
            end
        end else begin
            r = clamp_bcd(v - 24'd1);
        end
        return r;
`else
        return v - 24'd1;
`endif
    endfunction

    assign addr      = reg_addr_e'(avs_address);
    assign wr_value  = avs_write && (addr == ADDR_VALUE);
    assign wr_ctrl   = avs_write && (addr == ADDR_CTRL);
    assign wr_keycnt = avs_write && (addr == ADDR_KEYCNT);

    // Debounce: a level change is accepted on its DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        kdb_d = kdb_q;
        for (int unsigned i = 0; i < 4; i++) begin
            kcnt_d[i] = '0;
            if (ksync2_q[i] != kdb_q[i]) begin
                if (kcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) kdb_d[i] = ksync2_q[i];
                else kcnt_d[i] = kcnt_q[i] + 1'b1;
            end
        end
        press  = kdb_q & ~kdb_d;
        npress = 3'(press[0]) + 3'(press[1]) + 3'(press[2]) + 3'(press[3]);
    end

    always_comb begin
        value_d = value_q;
        if (wr_value)      value_d = avs_writedata[23:0];
        else if (press[2]) value_d = '0;
        else if (press[0]) value_d = val_inc(value_q);
        else if (press[1]) value_d = val_dec(value_q);

        ctrl_d = ctrl_q;
        if (wr_ctrl)       ctrl_d = avs_writedata & CTRL_MASK;
        else if (press[3]) ctrl_d[2] = ~ctrl_q[2];

        keycnt_d = wr_keycnt ? '0 : keycnt_q + 16'(npress);
    end

    always_comb begin
        tick_cnt_d = '0;
        tick       = 1'b0;
        if (ctrl_q[1] || ctrl_q[2]) begin
            if (tick_cnt_q == TW'(TICK_DIV - 1)) tick = 1'b1;
            else tick_cnt_d = tick_cnt_q + 1'b1;
        end

        phase_d = 1'b0;
        if (ctrl_q[1]) phase_d = tick ? ~phase_q : phase_q;

        offset_d = '0;
        if (ctrl_q[2]) begin
            if (tick) offset_d = (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
            else      offset_d = offset_q;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (addr)
                ADDR_VALUE:  rdata_d = {8'h00, value_q};
                ADDR_CTRL:   rdata_d = ctrl_q;
                ADDR_STATUS: rdata_d = {21'b0, offset_q, 3'b0, phase_q, kdb_q};
                default:     rdata_d = {16'h0000, keycnt_q};
            endcase
        end
    end

    // Digit k shows nibble (k + offset) mod 6; offset never exceeds 5 so one subtract suffices.
    always_comb begin
        for (int unsigned k = 0; k < 6; k++) begin
            int unsigned idx;
            idx = k + {29'b0, offset_q};
            if (idx >= 6) idx = idx - 6;
            if (!ctrl_q[0] || ctrl_q[8 + k] || phase_q) seg_d[k] = 7'h7F;
            else seg_d[k] = seg7(value_q[4*idx +: 4]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            value_q    <= '0;
            ctrl_q     <= 32'h0000_0001;
            keycnt_q   <= '0;
            offset_q   <= '0;
            phase_q    <= 1'b0;
            tick_cnt_q <= '0;
            ksync1_q   <= '1;
            ksync2_q   <= '1;
            kdb_q      <= '1;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) kcnt_q[i] <= '0;
            for (int unsigned k = 0; k < 6; k++) seg_q[k] <= 7'h7F;
        end else begin
            value_q    <= value_d;
            ctrl_q     <= ctrl_d;
            keycnt_q   <= keycnt_d;
            offset_q   <= offset_d;
            phase_q    <= phase_d;
            tick_cnt_q <= tick_cnt_d;
            ksync1_q   <= key_export;
            ksync2_q   <= ksync1_q;
            kdb_q      <= kdb_d;
            rdata_q    <= rdata_d;
            for (int unsigned i = 0; i < 4; i++) kcnt_q[i] <= kcnt_d[i];
            for (int unsigned k = 0; k < 6; k++) seg_q[k] <= seg_d[k];
        end
    end

    assign avs_readdata = rdata_q;
    assign hex_0_export = seg_q[0];
    assign hex_1_export = seg_q[1];
    assign hex_2_export = seg_q[2];
    assign hex_3_export = seg_q[3];
    assign hex_4_export = seg_q[4];
    assign hex_5_export = seg_q[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [3:0]  key;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0] hexv;
    logic [31:0] d;
    int unsigned checks = 0;
    int unsigned errors = 0;

    hex_display_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .key_export    (key),
        .hex_0_export  (hex0),
        .hex_1_export  (hex1),
        .hex_2_export  (hex2),
        .hex_3_export  (hex3),
        .hex_4_export  (hex4),
        .hex_5_export  (hex5)
    );

    always #5 clk = ~clk;
    assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        avs_address = a;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        v = avs_readdata;
    endtask

    task automatic press(input int unsigned i);
        key[i] = 1'b0;
        repeat (10) step();
        key[i] = 1'b1;
        repeat (10) step();
    endtask

    initial begin
        logic [23:0] exp_inc, exp_dec;
        rst_n = 1'b0; key = 4'hF;
        avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        repeat (3) step();
        chk("rst_hex", 64'(hexv), 64'({6{7'h7F}}));
        chk("rst_rdata", 64'(avs_readdata), 64'h0);

        rst_n = 1'b1;
        step();
        chk("hex_zero", 64'(hexv), 64'({6{7'h40}}));
        wr(2'd0, 32'h00C0FFEE);
        step();
        chk("hex_c0ffee", 64'(hexv), 64'({7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06}));
        rd(2'd2, d); chk("status_idle", 64'(d), 64'h0F);
        rd(2'd0, d); chk("value_trunc", 64'(d), 64'h00C0FFEE);

        // KEY0 wrap, then a too-short glitch
        wr(2'd0, 32'h00FFFFFF);
        press(0);
        rd(2'd0, d); chk("inc_wrap", 64'(d), 64'h0);
        rd(2'd3, d); chk("keycnt_1", 64'(d), 64'h1);
        key[0] = 1'b0; repeat (2) step(); key[0] = 1'b1; repeat (10) step();
        rd(2'd0, d); chk("glitch_value", 64'(d), 64'h0);
        rd(2'd3, d); chk("glitch_keycnt", 64'(d), 64'h1);

        // KEY2 beats KEY0; bus write beats KEY1
        wr(2'd0, 32'h5);
        wr(2'd3, 32'h0);
        key = 4'b1010; repeat (10) step(); key = 4'hF; repeat (10) step();
        rd(2'd0, d); chk("prio_k2", 64'(d), 64'h0);
        rd(2'd3, d); chk("keycnt_2", 64'(d), 64'h2);
        key[1] = 1'b0; repeat (4) step();
        wr(2'd0, 32'h123);
        repeat (5) step(); key[1] = 1'b1; repeat (10) step();
        rd(2'd0, d); chk("bus_wins", 64'(d), 64'h123);
        rd(2'd3, d); chk("keycnt_3", 64'(d), 64'h3);
        press(1);
        rd(2'd0, d); chk("dec", 64'(d), 64'h122);
        rd(2'd3, d); chk("keycnt_4", 64'(d), 64'h4);

`ifdef HEX_BCD_EN
        exp_inc = 24'h000000; exp_dec = 24'h999999;
`else
        exp_inc = 24'h99999A; exp_dec = 24'hFFFFFF;
`endif
        wr(2'd0, 32'h00999999); press(0);
        rd(2'd0, d); chk("inc_999999", 64'(d), 64'(exp_inc));
        wr(2'd0, 32'h0); press(1);
        rd(2'd0, d); chk("dec_zero", 64'(d), 64'(exp_dec));

        // Blink + scroll: ticks land on edges 4,8,..; outputs lag state by one edge
        wr(2'd0, 32'h00543210);
        wr(2'd1, 32'h07);
        for (int n = 1; n <= 29; n++) begin
            step();
            case (n)
                1:  chk("sc_n1",  64'(hex0), 64'h40);
                4:  chk("sc_n4",  64'(hex0), 64'h40);
                5:  chk("sc_n5",  64'(hex0), 64'h7F);
                9:  begin chk("sc_n9_h0", 64'(hex0), 64'h24); chk("sc_n9_h1", 64'(hex1), 64'h30); end
                13: chk("sc_n13", 64'(hex0), 64'h7F);
                17: begin chk("sc_n17_h0", 64'(hex0), 64'h19); chk("sc_n17_h5", 64'(hex5), 64'h30); end
                21: chk("sc_n21", 64'(hexv), 64'({6{7'h7F}}));
                25: begin chk("sc_n25_h0", 64'(hex0), 64'h40); chk("sc_n25_h1", 64'(hex1), 64'h79); end
                29: chk("sc_n29", 64'(hex0), 64'h7F);
                default: ;
            endcase
        end
        wr(2'd1, 32'h01);
        rd(2'd2, d); chk("status_pre", 64'(d), 64'h11F);
        rd(2'd2, d); chk("status_off0", 64'(d), 64'h0F);

        wr(2'd1, 32'h2A01);
        step();
        chk("mask", 64'(hexv), 64'({7'h7F, 7'h19, 7'h7F, 7'h24, 7'h7F, 7'h40}));
        rd(2'd1, d); chk("ctrl_rb", 64'(d), 64'h2A01);
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1, d); chk("ctrl_mask", 64'(d), 64'h3F07);

        wr(2'd1, 32'h05);
        repeat (6) step();
        rd(2'd0, d); chk("value_pre_rst", 64'(d), 64'h543210);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hex", 64'(hexv), 64'({6{7'h7F}}));
        chk("midrst_rdata", 64'(avs_readdata), 64'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        rd(2'd2, d); chk("post_rst_status", 64'(d), 64'h0F);
        rd(2'd0, d); chk("post_rst_value", 64'(d), 64'h0);
        rd(2'd1, d); chk("post_rst_ctrl", 64'(d), 64'h1);
        press(3);
        rd(2'd1, d); chk("key3_toggle", 64'(d), 64'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
